// File: rtl/i2c_slave_responder.sv
// ---------------------------------------------------------------------------
// i2c_slave_responder
//   Minimal I2C target that acknowledges one 7-bit address, accepts written
//   bytes and returns user-supplied bytes on master reads. All bus sensing is
//   done on synchronized copies of SCL/SDA; SCL is never stretched.
//
// Ports
//   clk      : system clock, rising edge
//   rst_b    : asynchronous active-low reset
//   scl_i    : bus SCL level (asynchronous)
//   sda_i    : bus SDA level (asynchronous)
//   sda_oe   : 1 pulls SDA low, 0 releases it (open-drain)
//   rx_data  : last byte written by the master
//   rx_valid : one-cycle pulse when rx_data updates
//   tx_data  : byte returned on the next master read byte
//   tx_load  : one-cycle pulse when tx_data is captured
//   busy     : high while this target is addressed
// ---------------------------------------------------------------------------
module i2c_slave_responder #(
  parameter logic [6:0] SLV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  // Synchronizer chains, reset to the idle bus level so that reset release
  // cannot fabricate a START or STOP.
  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_d_reg;
  logic                   sda_d_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          scl_sync_reg[gi] <= 1'b1;
          sda_sync_reg[gi] <= 1'b1;
        end else if (gi == 0) begin
          scl_sync_reg[gi] <= scl_i;
          sda_sync_reg[gi] <= sda_i;
        end else begin
          scl_sync_reg[gi] <= scl_sync_reg[(gi == 0) ? 0 : gi-1];
          sda_sync_reg[gi] <= sda_sync_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      scl_d_reg <= 1'b1;
      sda_d_reg <= 1'b1;
    end else begin
      scl_d_reg <= scl_sync_reg[SYNC_STAGES-1];
      sda_d_reg <= sda_sync_reg[SYNC_STAGES-1];
    end
  end

  logic scl_s, sda_s;
  logic start_det, stop_det, scl_rise, scl_fall;

  assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
  // SCL must be high in both the current and history sample, so an SCL and
  // SDA transition seen in the same cycle never reads as START/STOP.
  assign start_det = scl_s & scl_d_reg &  sda_d_reg & ~sda_s;
  assign stop_det  = scl_s & scl_d_reg & ~sda_d_reg &  sda_s;
  assign scl_rise  =  scl_s & ~scl_d_reg;
  assign scl_fall  = ~scl_s &  scl_d_reg;

  state_t     state_reg;
  logic [2:0] bit_cnt_reg;
  logic       byte_done_reg;   // 8th bit of the current byte has been clocked
  logic [7:0] shift_reg;       // incoming address/data bits
  logic [7:0] tx_shift_reg;    // outgoing byte, bit 7 is the one on the bus
  logic       nack_reg;        // master's acknowledge bit after a read byte
  logic       sda_oe_reg, rx_valid_reg, tx_load_reg, busy_reg;
  logic [7:0] rx_data_reg;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 3'd0;
      byte_done_reg <= 1'b0;
      shift_reg     <= 8'h00;
      tx_shift_reg  <= 8'h00;
      nack_reg      <= 1'b0;
      sda_oe_reg    <= 1'b0;
      rx_data_reg   <= 8'h00;
      rx_valid_reg  <= 1'b0;
      tx_load_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      tx_load_reg  <= 1'b0;
      if (start_det) begin
        state_reg     <= ADDR;
        bit_cnt_reg   <= 3'd0;
        byte_done_reg <= 1'b0;
        sda_oe_reg    <= 1'b0;
        busy_reg      <= 1'b0;
      end else if (stop_det) begin
        state_reg     <= IDLE;
        bit_cnt_reg   <= 3'd0;
        byte_done_reg <= 1'b0;
        sda_oe_reg    <= 1'b0;
        busy_reg      <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: ;
          ADDR: begin
            if (scl_rise) begin
              shift_reg   <= {shift_reg[6:0], sda_s};
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) byte_done_reg <= 1'b1;
            end else if (scl_fall && byte_done_reg) begin
              byte_done_reg <= 1'b0;
              if (shift_reg[7:1] == SLV_ADDR) begin
                state_reg  <= ADDR_ACK;
                sda_oe_reg <= 1'b1;
                busy_reg   <= 1'b1;
              end else begin
                state_reg <= IDLE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (shift_reg[0]) begin
                tx_shift_reg <= tx_data;
                tx_load_reg  <= 1'b1;
                sda_oe_reg   <= ~tx_data[7];
                state_reg    <= RD_DATA;
              end else begin
                sda_oe_reg <= 1'b0;
                state_reg  <= WR_DATA;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shift_reg   <= {shift_reg[6:0], sda_s};
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                rx_data_reg   <= {shift_reg[6:0], sda_s};
                rx_valid_reg  <= 1'b1;
                byte_done_reg <= 1'b1;
              end
            end else if (scl_fall && byte_done_reg) begin
              byte_done_reg <= 1'b0;
              sda_oe_reg    <= 1'b1;
              state_reg     <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe_reg <= 1'b0;
              state_reg  <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_rise) begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) byte_done_reg <= 1'b1;
            end else if (scl_fall) begin
              if (byte_done_reg) begin
                byte_done_reg <= 1'b0;
                sda_oe_reg    <= 1'b0;
                state_reg     <= RD_ACK;
              end else begin
                sda_oe_reg   <= ~tx_shift_reg[6];
                tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              nack_reg <= sda_s;
            end else if (scl_fall) begin
              if (nack_reg) begin
                state_reg  <= IDLE;
                sda_oe_reg <= 1'b0;
                busy_reg   <= 1'b0;
              end else begin
                tx_shift_reg <= tx_data;
                tx_load_reg  <= 1'b1;
                sda_oe_reg   <= ~tx_data[7];
                state_reg    <= RD_DATA;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign sda_oe   = sda_oe_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign tx_load  = tx_load_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_responder
//   Directed bench: a behavioural I2C master drives SCL/SDA (wired-AND with
//   the DUT's open-drain pull) and compares against hand-computed values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_slave_responder;

  localparam int SYNC = 2;
  localparam int Q    = 100;   // quarter SCL period in ns

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int rx_pulses = 0;
  int tx_pulses = 0;
  int oe_rises = 0;
  logic oe_prev = 1'b0;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_responder #(.SLV_ADDR(7'h50), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_b(rst_b), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_load(tx_load), .busy(busy)
  );

  always @(posedge clk) begin
    oe_prev <= sda_oe;
    if (rx_valid) rx_pulses <= rx_pulses + 1;
    if (tx_load) tx_pulses <= tx_pulses + 1;
    if (sda_oe && !oe_prev) oe_rises <= oe_rises + 1;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    b = sda_bus; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  initial begin
    logic       ack;
    logic       b;
    logic [7:0] d;
    int         rx_base, tx_base, oe_base;

    // Reset state
    #23;
    check_value("rst_sda_oe", sda_oe, 0);
    check_value("rst_busy", busy, 0);
    check_value("rst_rx_data", rx_data, 8'h00);
    check_value("rst_rx_valid", rx_valid, 0);
    check_value("rst_tx_load", tx_load, 0);
    rst_b = 1'b1;
    #(4*Q);

    // Write 0xA5 to 0x50
    rx_base = rx_pulses;
    i2c_start();
    write_byte(8'hA0, ack);
    check_value("wr_addr_ack", ack, 0);
    check_value("wr_busy", busy, 1);
    write_byte(8'hA5, ack);
    check_value("wr_data_ack", ack, 0);
    check_value("wr_rx_data", rx_data, 8'hA5);
    check_value("wr_rx_pulses", rx_pulses - rx_base, 1);
    i2c_stop();
    #(2*Q);
    check_value("wr_busy_stop", busy, 0);
    $display("txn write addr=0x50 data=0xA5 rx_data=0x%0h", rx_data);

    // Write to non-matching 0x51
    rx_base = rx_pulses;
    oe_base = oe_rises;
    i2c_start();
    write_byte(8'hA2, ack);
    check_value("miss_addr_nack", ack, 1);
    write_byte(8'h33, ack);
    check_value("miss_data_nack", ack, 1);
    check_value("miss_oe_rises", oe_rises - oe_base, 0);
    check_value("miss_rx_pulses", rx_pulses - rx_base, 0);
    check_value("miss_busy", busy, 0);
    i2c_stop();
    #(2*Q);
    $display("txn write addr=0x51 ignored");

    // Read 0x3C then 0xC3
    tx_base = tx_pulses;
    tx_data = 8'h3C;
    i2c_start();
    write_byte(8'hA1, ack);
    check_value("rd_addr_ack", ack, 0);
    tx_data = 8'hC3;
    read_byte(1'b0, d);
    check_value("rd_byte0", d, 8'h3C);
    read_byte(1'b1, d);
    check_value("rd_byte1", d, 8'hC3);
    #Q;
    check_value("rd_tx_loads", tx_pulses - tx_base, 2);
    check_value("rd_busy_nack", busy, 0);
    check_value("rd_oe_nack", sda_oe, 0);
    i2c_stop();
    #(2*Q);
    $display("txn read addr=0x50 bytes=0x3C,0xC3");

    // Write 0x12, repeated START, read 0x7E
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h12, ack);
    check_value("rs_wr_ack", ack, 0);
    check_value("rs_rx_data", rx_data, 8'h12);
    tx_data = 8'h7E;
    i2c_start();
    write_byte(8'hA1, ack);
    check_value("rs_addr_ack", ack, 0);
    read_byte(1'b1, d);
    check_value("rs_rd_byte", d, 8'h7E);
    i2c_stop();
    #(2*Q);
    $display("txn write 0x12 + rstart read got=0x%0h", d);

    // STOP after 4 bits of a read
    tx_data = 8'h3C;
    i2c_start();
    write_byte(8'hA1, ack);
    for (int i = 0; i < 4; i++) read_bit(b);
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1;
    #((SYNC + 2) * 10);
    check_value("mid_stop_oe", sda_oe, 0);
    check_value("mid_stop_busy", busy, 0);
    #Q;
    oe_base = oe_rises;
    scl_m = 1'b0; #Q;
    for (int i = 0; i < 9; i++) write_bit(1'b0);
    check_value("mid_stop_idle_oe", oe_rises - oe_base, 0);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #(2*Q);
    $display("txn read aborted by stop after 4 bits");

    // Asynchronous reset during the write ACK
    i2c_start();
    write_byte(8'hA0, ack);
    for (int i = 7; i >= 0; i--) write_bit(1'b1);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    check_value("ar_ack_driven", sda_oe, 1);
    rst_b = 1'b0;
    #1;
    check_value("ar_sda_oe", sda_oe, 0);
    check_value("ar_busy", busy, 0);
    check_value("ar_rx_data", rx_data, 8'h00);
    check_value("ar_rx_valid", rx_valid, 0);
    check_value("ar_tx_load", tx_load, 0);
    #Q;
    scl_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    rst_b = 1'b1;
    #(2*Q);
    check_value("ar_post_busy", busy, 0);
    $display("txn reset during write ack");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

Interface
REQ-001 SHALL provide parameter SLV_ADDR, default 7'h50: the 7-bit target address this block responds to.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2: synchronizer depth applied to scl_i and sda_i.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_b, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port scl_i, input, 1: bus SCL level (asynchronous to clk).
REQ-006 SHALL have port sda_i, input, 1: bus SDA level (asynchronous to clk).
REQ-007 SHALL have port sda_oe, output, 1: 1 pulls SDA low (open-drain); 0 releases SDA.
REQ-008 SHALL have port rx_data, output, 8: last byte written by the master.
REQ-009 SHALL have port rx_valid, output, 1: one-cycle pulse when rx_data updates.
REQ-010 SHALL have port tx_data, input, 8: byte to return on a master read.
REQ-011 SHALL have port tx_load, output, 1: one-cycle pulse when tx_data is captured; the user presents the next byte before the next read byte starts.
REQ-012 SHALL have port busy, output, 1: high while this target is addressed.

Function
REQ-013 SHALL synchronize scl_i/sda_i through SYNC_STAGES flops plus one history flop; all detection uses synchronized values only.
REQ-014 SHALL detect START as synced SDA 1->0 while synced SCL high, and STOP as SDA 0->1 while SCL high.
REQ-015 SHALL give START/STOP priority over any bit event in the same cycle.
REQ-016 SHALL sample SDA on the synced SCL rising edge, MSB first.
REQ-017 SHALL change sda_oe only in the cycle after a detected synced SCL falling edge, except on START/STOP release.
REQ-018 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-019 SHALL move from any state to ADDR on START, clearing the bit counter, releasing sda_oe and clearing busy; this covers repeated START.
REQ-020 SHALL move from any state to IDLE on STOP, releasing sda_oe and clearing busy.
REQ-021 SHALL, in ADDR, shift in 8 bits; on the following SCL fall, match byte[7:1]==SLV_ADDR -> ADDR_ACK, sda_oe=1, busy=1; mismatch -> IDLE, sda_oe stays 0.
REQ-022 SHALL, at the SCL fall ending ADDR_ACK: if R/W=0, go to WR_DATA with sda_oe=0; if R/W=1, capture tx_data, pulse tx_load, go to RD_DATA and drive sda_oe=~bit7.
REQ-023 SHALL, in WR_DATA, after the 8th SCL rise, update rx_data and pulse rx_valid for exactly one cycle, then ACK (sda_oe=1) from the next SCL fall to the one after, then return to WR_DATA.
REQ-024 SHALL, in RD_DATA, drive sda_oe=~bit on each SCL fall for bits 6..0; after bit 0's fall, release SDA and enter RD_ACK.
REQ-025 SHALL, in RD_ACK, sample the master's ACK on the SCL rise: on ACK(0), at the next fall capture tx_data, pulse tx_load, drive bit7 and go to RD_DATA; on NACK(1), go to IDLE with sda_oe=0 and busy=0.
REQ-026 SHALL ignore all SCL edges in IDLE; only START leaves IDLE.
REQ-027 SHALL use a bit counter of 0..7 that wraps to 0 at each byte boundary, with no other wrap.
REQ-028 SHALL never stretch SCL.

Reset
REQ-029 SHALL, while rst_b=0, force state=IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_load=0, busy=0, counters=0, and synchronizer flops=1.
REQ-030 SHALL have no pending action after rst_b is released; the first transaction requires a fresh START.

Verification
REQ-031 Write to 0x50 with data 0xA5 then STOP -> address ACK; rx_data=8'hA5 with a single rx_valid pulse; ACK; busy falls on STOP.
REQ-032 Address 0x51 write -> sda_oe never asserts; rx_valid never pulses; state IDLE.
REQ-033 Read from 0x50 with tx_data=0x3C then 0xC3, master ACKs the first byte and NACKs the second -> SDA bits 00111100, 11000011; two tx_load pulses; IDLE after NACK.
REQ-034 Write 0x12, then repeated START with read, tx_data=0x7E -> rx_data=8'h12; re-address ACK; 0x7E returned.
REQ-035 STOP injected mid-byte (after 4 bits of a read) -> sda_oe=0 within SYNC_STAGES+2 cycles; state IDLE.
REQ-036 rst_b asserted during WR_ACK -> sda_oe=0 immediately (asynchronous); all outputs at reset values.
